// File: rtl/bcd_seq_display.sv
// bcd_seq_display
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock)
// with saturating overflow and a multi-digit 7-segment encoder.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request conversion of bin_in (taken only while busy=0)
//   bin_in    unsigned value, sampled on the accept edge only
//   blank_lz  1 = blank leading zero digits (digit 0 always shown)
//   busy      conversion in progress
//   done      one-cycle pulse, bcd_out/overflow just updated
//   overflow  last result was >= 10^DIGITS (bcd_out saturated to all 9s)
//   bcd_out   registered BCD result, digit 0 (units) in bits [3:0]
//   seg_out   7-seg patterns, digit k in [7k+6:7k], bit order {g,f,e,d,c,b,a}
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0;
// there is no queueing, so start while busy=1 is simply dropped. Exactly
// BIN_W edges later the result registers together with a one-cycle done and
// busy falls, so a new start held high during the done cycle is taken at once.
module bcd_seq_display #(
  parameter int BIN_W          = 14,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   scratch_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               overflow_q;
  logic [BCD_W-1:0]   bcd_q;

  logic               accept;
  logic               last_shift;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [BIN_W-1:0]   bin_nxt;
  logic               carry_out;
  logic               ovf_nxt;

  assign accept     = start && (state_q == IDLE);
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // One double-dabble step: correct every digit >= 5, then shift the whole
  // {scratch, bin} chain left. A 1 leaving the top digit means the value has
  // passed 10^DIGITS and can never come back, so it is latched as overflow.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
    {carry_out, scratch_nxt, bin_nxt} = {adj, bin_q, 1'b0};
    ovf_nxt = ovf_q | carry_out;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        bin_q     <= bin_in;
        scratch_q <= '0;
        ovf_q     <= 1'b0;
        cnt_q     <= CNT_W'(BIN_W);
      end else if (state_q == SHIFT) begin
        bin_q     <= bin_nxt;
        scratch_q <= scratch_nxt;
        ovf_q     <= ovf_nxt;
        cnt_q     <= cnt_q - CNT_W'(1);
        if (last_shift) begin
          bcd_q      <= ovf_nxt ? {DIGITS{4'h9}} : scratch_nxt;
          overflow_q <= ovf_nxt;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd_out  = bcd_q;

  // Active-high segment pattern; codes A-F cannot occur and show blank.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h00;
    endcase
  endfunction

  // Scan from the top digit down: a digit is a leading zero while every
  // digit at or above it is zero. Saturated results are never blanked.
  logic             zero_run;
  logic [6:0]       pat;
  always_comb begin
    seg_out  = '0;
    zero_run = 1'b1;
    pat      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
      if (blank_lz && !overflow_q && zero_run && (k != 0)) pat = 7'h00;
      else                                                 pat = enc7(bcd_q[4*k +: 4]);
      seg_out[7*k +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

endmodule
